// File: rtl/param_seq_detector_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the runtime-programmable serial pattern detector.
//   DEF_PATTERN / DEF_LEN / DEF_OVERLAP : configuration loaded at reset,
//                                         giving the classic 10110
//                                         non-overlapping detector
//   match_mode_e                        : overlapping / non-overlapping mode
//   clampLen()                          : limits a requested length to the
//                                         maximum the hardware supports
//   lenMask()                           : mask with the low 'len' bits set
// ---------------------------------------------------------------------------
package seq_det_pkg;

  // Reset pattern is held as a wide constant so that any MAX_LEN can take
  // its low bits without a width mismatch.
  localparam logic [63:0] DEF_PATTERN = 64'h0000_0000_0000_0016;
  localparam int          DEF_LEN     = 5;

  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } match_mode_e;

  localparam match_mode_e DEF_OVERLAP = MODE_NON_OVERLAP;

  // Oversized lengths behave as the longest pattern the history can hold.
  function automatic int clampLen(input int len, input int maxLen);
    return (len > maxLen) ? maxLen : len;
  endfunction

  // Mask selecting the low 'len' bits; saturates at the full 64-bit width.
  function automatic logic [63:0] lenMask(input int len);
    if (len >= 64) begin
      return '1;
    end
    return (64'd1 << len) - 64'd1;
  endfunction

endpackage

// File: rtl/param_seq_detector_counter.sv
// ---------------------------------------------------------------------------
// seq_sat_counter
// Saturating event counter with synchronous clear.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, count returns to 0
//   i_clr   : synchronous clear; an increment in the same cycle still counts
//   i_inc   : count one event
//   o_count : current count, sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module seq_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear takes priority over the held value, but an event arriving in the
  // clearing cycle is kept so the count restarts at 1 rather than losing
  // it. Otherwise increment until every bit is set and then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/param_seq_detector.sv
// ---------------------------------------------------------------------------
// param_seq_detector
// Runtime-programmable serial bit-pattern detector with optional overlap,
// sample-enable qualified input and a saturating match counter.
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   i_en           : sample strobe, i_din consumed only when high
//   i_din          : serial data bit
//   i_cfg_load     : one-cycle pulse latching pattern/length/overlap
//   i_cfg_pattern  : pattern, bit [len-1] received first, bit [0] last
//   i_cfg_len      : pattern length (0 disables, >MAX_LEN clamped)
//   i_cfg_overlap  : 1 = overlapping matches, 0 = non-overlapping
//   i_clr_count    : synchronous clear of the match counter
//   o_dout         : registered one-cycle match pulse
//   o_match_count  : saturating number of matches
//   o_fill         : number of valid history bits currently held
// ---------------------------------------------------------------------------
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_din,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_clr_count,
  output logic               o_dout,
  output logic [CNT_W-1:0]   o_match_count,
  output logic [LEN_W-1:0]   o_fill
);

  localparam logic [LEN_W-1:0] RESET_LEN = LEN_W'(clampLen(DEF_LEN, MAX_LEN));

  // Shadow configuration
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  match_mode_e        r_mode;

  // The oldest history bit is never compared (the newest comes straight
  // from i_din), so only MAX_LEN-1 bits need storing.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_dout;

  logic [MAX_LEN-1:0] w_histNext;
  logic [63:0]        w_mask;
  logic [LEN_W:0]     w_fillInc;
  logic               w_enough;
  logic               w_patEq;
  logic               w_sample;
  logic               w_hit;
  logic [LEN_W-1:0]   w_fillNext;
  logic [LEN_W-1:0]   w_cfgLen;

  assign w_cfgLen   = LEN_W'(clampLen(int'(i_cfg_len), MAX_LEN));
  assign w_histNext = {r_hist, i_din};
  assign w_mask     = lenMask(int'(r_len));
  assign w_fillInc  = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
  assign w_enough   = (w_fillInc >= {1'b0, r_len});
  assign w_patEq    = ((64'(w_histNext) & w_mask) == (64'(r_pattern) & w_mask));

  // A cfg_load cycle swallows any coincident sample, and a zero length
  // disables matching entirely (the empty mask would otherwise always hit).
  assign w_sample = i_en & ~i_cfg_load;
  assign w_hit    = w_sample & (r_len != '0) & w_enough & w_patEq;

  // Fill tracks how many fresh bits count towards the next match. After an
  // overlapping hit the whole window stays usable; after a non-overlapping
  // hit the window restarts empty. Otherwise it grows up to the length.
  always_comb begin
    w_fillNext = r_fill;
    if (w_hit) begin
      w_fillNext = (r_mode == MODE_OVERLAP) ? r_len : '0;
    end else if (w_enough) begin
      w_fillNext = r_len;
    end else begin
      w_fillNext = w_fillInc[LEN_W-1:0];
    end
  end

  // Configuration shadow registers only change on an explicit load; reset
  // restores the 10110 non-overlapping detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= DEF_PATTERN[MAX_LEN-1:0];
      r_len     <= RESET_LEN;
      r_mode    <= DEF_OVERLAP;
    end else if (i_cfg_load) begin
      r_pattern <= i_cfg_pattern;
      r_len     <= w_cfgLen;
      r_mode    <= match_mode_e'(i_cfg_overlap);
    end
  end

  // Shift in qualified samples and register the match pulse. Loading a new
  // configuration discards any partial match. Idle cycles keep history and
  // fill so gaps in the sample strobe never break a match in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (i_cfg_load) begin
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (i_en) begin
      r_hist <= w_histNext[MAX_LEN-2:0];
      r_fill <= w_fillNext;
      r_dout <= w_hit;
    end else begin
      r_dout <= 1'b0;
    end
  end

  seq_sat_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_clr_count),
    .i_inc   (w_hit),
    .o_count (o_match_count)
  );

  assign o_dout = r_dout;
  assign o_fill = r_fill;

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Runtime-programmable serial bit-pattern detector, generalised from the fixed 10110 non-overlapping FSM detector.
- Pattern length is configurable up to MAX_LEN bits. Overlapping or non-overlapping mode is selected at runtime.
- Input is qualified by a sample enable. A saturating match counter is included.
- Sits on serial bitstream paths (UART/line decoders) as a frame-marker or keyword detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>= 2).
- CNT_W, 16, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  sample strobe; din is consumed only on edges where en=1.
- din  in  1  serial data bit.
- cfg_load  in  1  one-cycle pulse; latches cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count.
- dout  out  1  one-cycle match pulse, registered.
- match_count  out  CNT_W  saturating number of matches.
- fill  out  LEN_W  number of valid history bits currently held (debug/status).

Behaviour:
- Reset (asynchronous, active-high, clock clk):
  - dout=0, match_count=0, fill=0, history=0.
  - Shadow config = pattern 8'b0001_0110 (low MAX_LEN bits), len=5, overlap=0. This is the 10110 non-overlapping detector.
- Config shadow registers:
  - Updated only on cfg_load.
  - Effective length: cfg_len=0 disables detection (dout never asserts, fill held at 0); cfg_len>MAX_LEN is clamped to MAX_LEN.
  - cfg_load also clears fill and history.
  - If en=1 in the same cycle as cfg_load, that sample is dropped and dout=0 next cycle.
- Sampling, on each rising edge with en=1 and no cfg_load:
  - hist_n = {hist[MAX_LEN-2:0], din}; hist <= hist_n.
  - hit = (fill+1 >= len) AND (hist_n[len-1:0] == pattern[len-1:0]).
  - dout <= hit. Latency: dout is high for exactly the one cycle after the edge that samples the final pattern bit.
  - If hit: overlap=1 → fill <= len; overlap=0 → fill <= 0, so the next match needs len fresh bits.
  - If no hit: fill <= min(fill+1, len).
- en=0 cycles: hist and fill hold, dout <= 0. Gaps between samples never break a partial match.
- Match counter:
  - Increments on hit and saturates at all-ones (no wrap).
  - clr_count alone → 0. clr_count with a hit in the same cycle → 1 (the match is not lost).
- Reset mid-operation: all state returns to reset values immediately; a partial match is discarded.
- No X propagation: all registers have reset values.

Decomposition:
- Package seq_det_pkg:
  - reset-default constants: DEF_PATTERN, DEF_LEN=5, DEF_OVERLAP=0;
  - a len-clamp function;
  - a helper producing a width mask for a given len.
- One natural sub-module: seq_sat_counter, parameter W, with ports clk, rst, clr, inc, count. It implements saturate-and-clear-wins-then-increment.

Test Plan:
- Defaults after reset, en=1 every cycle, stream 1,0,1,1,0,1,1,0 → dout pulses once, the cycle after bit 5; match_count=1. Repeat after cfg_load overlap=1 → pulses after bits 5 and 8; count=2.
- Pattern 3'b111, len=3:
  - overlap=1 with six 1s → pulses after bits 3, 4, 5, 6; count=4.
  - overlap=0 with six 1s → pulses after bits 3 and 6; count=2.
- Defaults, stream 1,0,1,1,0 with en low for 3 cycles between each bit → one pulse, one cycle after the 5th en-qualified edge; dout=0 during all gaps.
- Stream 1,0,1,1, then cfg_load (same config) with en=1 and din=0 → no pulse, fill=0. Next 1,0,1,1,0 → pulse.
- CNT_W=2, five matches → match_count sticks at 3. clr_count coincident with a hit → 1. cfg_len=0 with any stream → no pulses. cfg_len=15 with MAX_LEN=8 → behaves as len 8.
- Assert rst asynchronously mid-pattern (after 1,0,1,1), between clock edges → dout/fill/count go to 0 immediately. After release, 0 alone gives no pulse; a full 1,0,1,1,0 gives a pulse.
